// File: rtl/led_pkg.sv
// Shared definitions for the pushbutton conditioner: channel FSM states,
// default timing constants and a small width helper.
package led_pkg;

   typedef enum logic [1:0] {
      ST_RELEASED   = 2'd0,
      ST_DB_PRESS   = 2'd1,
      ST_PRESSED    = 2'd2,
      ST_DB_RELEASE = 2'd3
   } btn_state_e;

   localparam int DEF_NUM_BTN         = 3;
   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEF_REPEAT_DELAY    = 50_000_000;
   localparam int DEF_REPEAT_RATE     = 10_000_000;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/button_channel.sv
// One pushbutton channel: 2-flop synchronizer, debounce FSM and auto-repeat timer.
//
//   state          | meaning
//   ST_RELEASED    | stable released, waiting for sync=1
//   ST_DB_PRESS    | sync=1 seen, counting stable cycles towards a press
//   ST_PRESSED     | stable pressed, repeat timer running
//   ST_DB_RELEASE  | sync=0 seen, counting stable cycles towards a release
module button_channel
   import led_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic repeat_o
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int RW = $clog2(max3(REPEAT_DELAY, REPEAT_RATE, 1)) + 1;
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RD_C    = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] RR_C    = RW'(REPEAT_RATE);

   logic [1:0]    sync_q;
   logic          sync;
   btn_state_e    state_q, state_d;
   logic [DW-1:0] db_cnt_q, db_cnt_d, db_inc;
   logic [RW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_inc;
   logic          rpt_phase_q, rpt_phase_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          repeat_q, repeat_d;

   assign sync    = sync_q[1];
   assign db_inc  = (db_cnt_q == '1) ? db_cnt_q : db_cnt_q + DW'(1);
   assign rpt_inc = (rpt_cnt_q == '1) ? rpt_cnt_q : rpt_cnt_q + RW'(1);

   always_comb begin
      state_d     = state_q;
      db_cnt_d    = db_cnt_q;
      rpt_cnt_d   = rpt_cnt_q;
      rpt_phase_d = rpt_phase_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      repeat_d    = 1'b0;
      case (state_q)
         ST_RELEASED: begin
            if (sync) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d     = ST_PRESSED;
                  rpt_cnt_d   = '0;
                  rpt_phase_d = 1'b0;
                  press_d     = 1'b1;
                  repeat_d    = 1'b1;
               end else begin
                  state_d  = ST_DB_PRESS;
                  db_cnt_d = DW'(1);
               end
            end
         end
         ST_DB_PRESS: begin
            if (!sync) begin
               state_d  = ST_RELEASED;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d     = ST_PRESSED;
               db_cnt_d    = '0;
               rpt_cnt_d   = '0;
               rpt_phase_d = 1'b0;
               press_d     = 1'b1;
               repeat_d    = 1'b1;
            end else begin
               db_cnt_d = db_inc;
            end
         end
         ST_PRESSED: begin
            // Phase 0 waits REPEAT_DELAY, phase 1 then ticks every REPEAT_RATE.
            rpt_cnt_d = rpt_inc;
            if (REPEAT_DELAY != 0) begin
               if ((!rpt_phase_q && rpt_inc == RD_C) || (rpt_phase_q && rpt_inc == RR_C)) begin
                  repeat_d    = 1'b1;
                  rpt_cnt_d   = '0;
                  rpt_phase_d = 1'b1;
               end
            end
            if (!sync) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d   = ST_RELEASED;
                  release_d = 1'b1;
               end else begin
                  state_d  = ST_DB_RELEASE;
                  db_cnt_d = DW'(1);
               end
            end
         end
         ST_DB_RELEASE: begin
            if (sync) begin
               state_d  = ST_PRESSED;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d   = ST_RELEASED;
               db_cnt_d  = '0;
               release_d = 1'b1;
            end else begin
               db_cnt_d = db_inc;
            end
         end
         default: begin
            state_d  = ST_RELEASED;
            db_cnt_d = '0;
         end
      endcase
      level_d = (state_d == ST_PRESSED) || (state_d == ST_DB_RELEASE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q      <= '0;
         state_q     <= ST_RELEASED;
         db_cnt_q    <= '0;
         rpt_cnt_q   <= '0;
         rpt_phase_q <= 1'b0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         repeat_q    <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], raw_i};
         state_q     <= state_d;
         db_cnt_q    <= db_cnt_d;
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_phase_q <= rpt_phase_d;
         level_q     <= level_d;
         press_q     <= press_d;
         release_q   <= release_d;
         repeat_q    <= repeat_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign repeat_o  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounce and auto-repeat conditioner for NUM_BTN independent pushbuttons.
module button_conditioner
   import led_pkg::*;
#(
   parameter int NUM_BTN         = DEF_NUM_BTN,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_BTN-1:0] btn_repeat
);

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .raw_i     (btn_raw[g]),
         .level_o   (btn_level[g]),
         .press_o   (btn_press[g]),
         .release_o (btn_release[g]),
         .repeat_o  (btn_repeat[g])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] btn_raw = '0;
   logic [2:0] btn_level, btn_press, btn_release, btn_repeat;
   int         checks = 0;
   int         errors = 0;

   button_conditioner #(
      .NUM_BTN         (3),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_RATE     (3)
   ) dut (
      .clk         (clk),
      .reset       (rst_n),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_repeat  (btn_repeat)
   );

   always #5 clk = ~clk;

   // Tick t=1 is the edge that first samples a value driven before it, so a
   // press held from there shows up after tick 6 (edge 0 plus DEBOUNCE_CYCLES+1).
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      btn_raw = '0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      btn_raw = 3'b111;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_repeat} !== 12'h000) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=000", {btn_level, btn_press, btn_release, btn_repeat});
      end
      btn_raw = '0;
      rst_n = 1'b1;
      idle(8);
      checks++;
      if ({btn_level, btn_press, btn_release, btn_repeat} !== 12'h000) begin
         errors++;
         $display("FAIL reset_idle got=%h exp=000", {btn_level, btn_press, btn_release, btn_repeat});
      end
   endtask

   task automatic test_press_release();
      btn_raw = 3'b001;
      for (int t = 1; t <= 8; t++) begin
         tick();
         checks++;
         if ({btn_level[0], btn_press[0], btn_repeat[0]} !== {t >= 6, t == 6, t == 6}) begin
            errors++;
            $display("FAIL press0 t=%0d got lvl/prs/rpt=%b exp=%b", t,
                     {btn_level[0], btn_press[0], btn_repeat[0]}, {t >= 6, t == 6, t == 6});
         end
      end
      btn_raw = 3'b000;
      for (int t = 1; t <= 8; t++) begin
         tick();
         checks++;
         if ({btn_level[0], btn_release[0], btn_press[0]} !== {t < 6, t == 6, 1'b0}) begin
            errors++;
            $display("FAIL release0 t=%0d got lvl/rel/prs=%b exp=%b", t,
                     {btn_level[0], btn_release[0], btn_press[0]}, {t < 6, t == 6, 1'b0});
         end
      end
   endtask

   task automatic test_glitch();
      int np, nr;
      for (int t = 1; t <= 12; t++) begin
         btn_raw = (t <= 3) ? 3'b010 : 3'b000;
         tick();
         checks++;
         if ({btn_level[1], btn_press[1], btn_release[1], btn_repeat[1]} !== 4'b0000) begin
            errors++;
            $display("FAIL glitch3 t=%0d got=%b exp=0000", t,
                     {btn_level[1], btn_press[1], btn_release[1], btn_repeat[1]});
         end
      end
      np = 0;
      nr = 0;
      for (int t = 1; t <= 15; t++) begin
         btn_raw = (t <= 4) ? 3'b010 : 3'b000;
         tick();
         np += int'(btn_press[1]);
         nr += int'(btn_release[1]);
      end
      checks++;
      if (np != 1 || nr != 1) begin
         errors++;
         $display("FAIL glitch4 presses=%0d releases=%0d exp=1/1", np, nr);
      end
   endtask

   task automatic test_repeat();
      int nr;
      logic exp_rpt;
      btn_raw = 3'b100;
      for (int t = 1; t <= 33; t++) begin
         tick();
         exp_rpt = (t == 6) || ((t - 6) >= 10 && ((t - 16) % 3) == 0);
         checks++;
         if ({btn_repeat[2], btn_press[2]} !== {exp_rpt, t == 6}) begin
            errors++;
            $display("FAIL repeat2 t=%0d got rpt/prs=%b exp=%b", t,
                     {btn_repeat[2], btn_press[2]}, {exp_rpt, t == 6});
         end
      end
      btn_raw = 3'b000;
      nr = 0;
      for (int t = 1; t <= 10; t++) begin
         tick();
         nr += int'(btn_release[2]);
      end
      checks++;
      if (nr != 1 || btn_level[2] !== 1'b0) begin
         errors++;
         $display("FAIL repeat2_release releases=%0d lvl=%b exp=1/0", nr, btn_level[2]);
      end
   endtask

   task automatic test_bounce();
      logic exp_rpt;
      // A 2-cycle low dip while held: repeat counter holds in DB_RELEASE, so
      // the first repeat slips from t=16 to t=18.
      for (int t = 1; t <= 25; t++) begin
         btn_raw = (t <= 8 || t >= 11) ? 3'b001 : 3'b000;
         tick();
         exp_rpt = (t == 6) || (t == 18) || (t == 21) || (t == 24);
         checks++;
         if ({btn_repeat[0], btn_level[0], btn_release[0]} !== {exp_rpt, t >= 6, 1'b0}) begin
            errors++;
            $display("FAIL hold_dip t=%0d got rpt/lvl/rel=%b exp=%b", t,
                     {btn_repeat[0], btn_level[0], btn_release[0]}, {exp_rpt, t >= 6, 1'b0});
         end
      end
      for (int t = 1; t <= 12; t++) begin
         btn_raw = (t == 2 || t == 3) ? 3'b001 : 3'b000;
         tick();
         checks++;
         if ({btn_release[0], btn_level[0], btn_press[0]} !== {t == 9, t < 9, 1'b0}) begin
            errors++;
            $display("FAIL release_bounce t=%0d got rel/lvl/prs=%b exp=%b", t,
                     {btn_release[0], btn_level[0], btn_press[0]}, {t == 9, t < 9, 1'b0});
         end
      end
   endtask

   task automatic test_simultaneous();
      btn_raw = 3'b111;
      for (int t = 5; t <= 7; t++) begin
         if (t == 5) for (int i = 0; i < 5; i++) tick(); else tick();
         checks++;
         if ({btn_press, btn_repeat} !== ((t == 6) ? 6'b111111 : 6'b000000)) begin
            errors++;
            $display("FAIL simul_press t=%0d got prs/rpt=%b exp=%b", t,
                     {btn_press, btn_repeat}, (t == 6) ? 6'b111111 : 6'b000000);
         end
      end
      btn_raw = 3'b000;
      for (int t = 1; t <= 7; t++) begin
         tick();
         checks++;
         if (btn_release !== ((t == 6) ? 3'b111 : 3'b000)) begin
            errors++;
            $display("FAIL simul_release t=%0d got=%b exp=%b", t, btn_release,
                     (t == 6) ? 3'b111 : 3'b000);
         end
      end
   endtask

   task automatic test_reset_mid();
      int np;
      btn_raw = 3'b001;
      for (int i = 0; i < 4; i++) tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({btn_level, btn_press, btn_release, btn_repeat} !== 12'h000) begin
         errors++;
         $display("FAIL reset_db_press got=%h exp=000", {btn_level, btn_press, btn_release, btn_repeat});
      end
      tick();
      tick();
      rst_n = 1'b1;
      for (int t = 1; t <= 10; t++) begin
         tick();
         checks++;
         if ({btn_press[0], btn_level[0]} !== {t == 6, t >= 6}) begin
            errors++;
            $display("FAIL press_after_reset t=%0d got prs/lvl=%b exp=%b", t,
                     {btn_press[0], btn_level[0]}, {t == 6, t >= 6});
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({btn_level, btn_press, btn_release, btn_repeat} !== 12'h000) begin
         errors++;
         $display("FAIL reset_pressed got=%h exp=000", {btn_level, btn_press, btn_release, btn_repeat});
      end
      btn_raw = 3'b000;
      tick();
      rst_n = 1'b1;
      np = 0;
      for (int t = 1; t <= 20; t++) begin
         tick();
         np += int'(|{btn_press, btn_release, btn_repeat, btn_level});
      end
      checks++;
      if (np != 0) begin
         errors++;
         $display("FAIL reset_discard active_cycles=%0d exp=0", np);
      end
   endtask

   initial begin
      test_reset();
      test_press_release();
      idle(4);
      test_glitch();
      idle(4);
      test_repeat();
      idle(4);
      test_bounce();
      idle(4);
      test_simultaneous();
      idle(4);
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter NUM_BTN, default 3: number of independent button channels, 1..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_000_000: stable cycles required to accept a level change (10 ms at 100 MHz); minimum 1.
REQ-003 Parameter REPEAT_DELAY, default 50_000_000: cycles from accepted press to first auto-repeat pulse; 0 disables auto-repeat.
REQ-004 Parameter REPEAT_RATE, default 10_000_000: cycles between subsequent auto-repeat pulses; minimum 1.
REQ-005 clk  input  1  system clock, 100 MHz on Basys 3.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 btn_raw  input  NUM_BTN  raw asynchronous pushbutton levels, 1 = pressed.
REQ-008 btn_level  output  NUM_BTN  debounced level per channel.
REQ-009 btn_press  output  NUM_BTN  one-cycle pulse on accepted press.
REQ-010 btn_release  output  NUM_BTN  one-cycle pulse on accepted release.
REQ-011 btn_repeat  output  NUM_BTN  one-cycle pulse on accepted press and on every auto-repeat tick.

Function
REQ-012 Each btn_raw bit SHALL pass through a 2-flop synchronizer; only the second stage (sync) drives the FSM.
REQ-013 Each channel SHALL run an independent FSM with states RELEASED, DB_PRESS, PRESSED, DB_RELEASE and a debounce counter.
REQ-014 RELEASED: sync=1 -> DB_PRESS with counter=1 (or directly PRESSED if DEBOUNCE_CYCLES=1); else stay.
REQ-015 DB_PRESS: sync=0 -> RELEASED, counter=0; counter=DEBOUNCE_CYCLES-1 with sync=1 -> PRESSED; else counter increments.
REQ-016 PRESSED and DB_RELEASE SHALL mirror REQ-014/015 with sync inverted; DB_RELEASE bounce returns to PRESSED.
REQ-017 btn_level SHALL be 1 in PRESSED and DB_RELEASE, 0 otherwise; all outputs registered.
REQ-018 btn_press and btn_repeat SHALL pulse for exactly one cycle on the transition into PRESSED from DB_PRESS; btn_release on transition into RELEASED from DB_RELEASE.
REQ-019 Latency: raw held stable from sampling edge 0, btn_level/btn_press SHALL assert after edge DEBOUNCE_CYCLES+1.
REQ-020 Repeat counter SHALL clear on entry to PRESSED from DB_PRESS, increment each cycle in PRESSED, hold in DB_RELEASE, and resume unchanged on return to PRESSED.
REQ-021 With REPEAT_DELAY>0, btn_repeat SHALL pulse when counter reaches REPEAT_DELAY, then every REPEAT_RATE cycles thereafter, while in PRESSED.
REQ-022 Counters SHALL saturate rather than wrap; widths SHALL be $clog2 of the largest relevant parameter plus 1.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-024 No pulse SHALL be emitted for any raw glitch shorter than DEBOUNCE_CYCLES synchronized cycles.

Reset
REQ-025 reset low SHALL asynchronously clear synchronizers, counters, all outputs to 0 and every FSM to RELEASED.
REQ-026 A button held through reset deassertion SHALL be debounced as a new press and produce btn_press.
REQ-027 Reset asserted mid-debounce or mid-repeat SHALL discard the operation with no pulse emitted.

Structure
REQ-028 FSM state enum and default parameter constants SHALL live in shared package led_pkg.
REQ-029 Per-channel logic SHALL be sub-module button_channel, instantiated NUM_BTN times by generate.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-030 btn_raw[0] 0->1 held -> btn_level[0]=1 and btn_press[0]/btn_repeat[0] single pulse after edge 5.
REQ-031 btn_raw[1] pulses high 3 cycles then low -> no output change on channel 1.
REQ-032 btn_raw[2] held 30 cycles -> btn_repeat[2] pulses at 0, 10, 13, 16, 19, 22, 25 cycles after press.
REQ-033 Held button released, bounces high 2 cycles mid-release -> single btn_release after 4 stable low cycles; repeat phase preserved.
REQ-034 All three raw inputs rise same cycle -> btn_press=3'b111 for exactly one cycle.
REQ-035 reset pulsed low during DB_PRESS with raw held -> outputs 0 immediately; press pulse 5 edges after reset release.
